// File: rtl/pa_risc_pkg.sv
// Shared PA-RISC front-end definitions: address geometry, redirect FSM
// encoding and the redirect request record.
package pa_risc_pkg;

  localparam int ADDR_W     = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // {J, n, tgt} as produced by the condition handler
  typedef struct packed {
    logic              j;
    logic              n;
    logic [ADDR_W-1:0] tgt;
  } redir_req_t;

endpackage

// File: rtl/redirect_buf.sv
// Single-entry holding register for a redirect request. The first load
// wins until the entry is cleared; clear beats load.
module redirect_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// PA-RISC PC/nPC pair with delayed branching, delay-slot nullification and
// a one-deep buffer that holds a branch resolved while the front end stalls.
module pc_redirect_unit #(
  parameter int                ADDR_W     = pa_risc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                INSN_BYTES = pa_risc_pkg::INSN_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic              br_valid,
  input  logic              J,
  input  logic              n_in,
  input  logic [ADDR_W-1:0] tgt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              nullify,
  output logic              redirect_pend
);
  import pa_risc_pkg::state_t;
  import pa_risc_pkg::IDLE;
  import pa_risc_pkg::PEND;

  // Same layout as pa_risc_pkg::redir_req_t, sized by this instance's ADDR_W
  typedef struct packed {
    logic              j;
    logic              n;
    logic [ADDR_W-1:0] tgt;
  } req_t;

  localparam int                REQ_W = $bits(req_t);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSN_BYTES);

  state_t            state;
  req_t              in_req;
  req_t              buf_req;
  req_t              act_req;
  logic [REQ_W-1:0]  buf_q;
  logic              buf_load;
  logic              buf_clear;
  logic              take;
  logic [ADDR_W-1:0] seq_npc;

  always_comb begin
    in_req.j   = J;
    in_req.n   = n_in;
    in_req.tgt = {tgt[ADDR_W-1:2], 2'b00};
    buf_req    = req_t'(buf_q);
    // while pending, the latched request is the only one that counts
    act_req    = (state == PEND) ? buf_req : in_req;
    take       = (state == PEND) || br_valid;
    buf_load   = (state == IDLE) && !le && br_valid;
    buf_clear  = (state == PEND) && le;
    seq_npc    = npc + STEP;
  end

  redirect_buf #(.W(REQ_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (REQ_W'(in_req)),
    .dout  (buf_q),
    .valid (redirect_pend)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      npc     <= RESET_PC + STEP;
      nullify <= 1'b0;
      state   <= IDLE;
    end else if (le) begin
      // the delay slot always issues; only npc is redirected
      pc      <= npc;
      npc     <= (take && act_req.j) ? act_req.tgt : seq_npc;
      nullify <= take && act_req.n;
      state   <= IDLE;
    end else if (state == IDLE && br_valid) begin
      state   <= PEND;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed table-driven bench for pc_redirect_unit plus a long-stall sequence.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, le, br_valid, J, n_in;
  logic [31:0] tgt;
  logic [31:0] pc, npc;
  logic        nullify, redirect_pend;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INSN_BYTES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .br_valid      (br_valid),
    .J             (J),
    .n_in          (n_in),
    .tgt           (tgt),
    .pc            (pc),
    .npc           (npc),
    .nullify       (nullify),
    .redirect_pend (redirect_pend)
  );

  typedef struct {
    logic        rst, le, bv, j, n;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_npc;
    logic        e_null, e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, le_i, bv, j, n, input logic [31:0] t,
                     input logic [31:0] epc, enpc, input logic enul, epend);
    vec_t v;
    v.rst = rst; v.le = le_i; v.bv = bv; v.j = j; v.n = n; v.tgt = t;
    v.e_pc = epc; v.e_npc = enpc; v.e_null = enul; v.e_pend = epend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, le_i, bv, j, n, input logic [31:0] t);
    @(negedge clk);
    reset = rst; le = le_i; br_valid = bv; J = j; n_in = n; tgt = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [31:0] epc, enpc,
                         input logic enul, epend);
    chk({tag, ".pc"}, idx, pc, epc);
    chk({tag, ".npc"}, idx, npc, enpc);
    chk({tag, ".nullify"}, idx, {31'b0, nullify}, {31'b0, enul});
    chk({tag, ".pend"}, idx, {31'b0, redirect_pend}, {31'b0, epend});
  endtask

  initial begin
    reset = 1'b1; le = 1'b0; br_valid = 1'b0; J = 1'b0; n_in = 1'b0; tgt = '0;

    //  rst le bv j n  tgt            pc            npc          nul pend
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h4,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h4,        32'h8,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h8,        32'hC,        0, 0);
    add(0, 1, 1, 1, 0, 32'h100,       32'hC,        32'h100,      0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h100,      32'h104,      0, 0);
    add(0, 1, 1, 1, 1, 32'h203,       32'h104,      32'h200,      1, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h200,      32'h204,      0, 0);
    add(0, 1, 1, 1, 0, 32'h40,        32'h204,      32'h40,       0, 0);
    add(0, 1, 0, 1, 1, 32'h999,       32'h40,       32'h44,       0, 0);
    add(0, 1, 1, 0, 1, 32'h999,       32'h44,       32'h48,       1, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h48,       32'h4C,       0, 0);
    // nullify holds across a plain stall
    add(0, 1, 1, 0, 1, 32'h0,         32'h4C,       32'h50,       1, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h4C,       32'h50,       1, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h50,       32'h54,       0, 0);
    // stalled branch to 0x300; later 0x500 offers are ignored
    add(0, 0, 1, 1, 0, 32'h300,       32'h50,       32'h54,       0, 1);
    add(0, 0, 1, 1, 1, 32'h500,       32'h50,       32'h54,       0, 1);
    add(0, 0, 1, 1, 1, 32'h500,       32'h50,       32'h54,       0, 1);
    add(0, 0, 1, 1, 1, 32'h500,       32'h50,       32'h54,       0, 1);
    add(0, 1, 1, 1, 1, 32'h500,       32'h54,       32'h300,      0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h300,      32'h304,      0, 0);
    // stalled not-taken nullifying branch
    add(0, 0, 1, 0, 1, 32'h0,         32'h300,      32'h304,      0, 1);
    add(0, 1, 0, 0, 0, 32'h0,         32'h304,      32'h308,      1, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h308,      32'h30C,      0, 0);
    // reset discards a pending request
    add(0, 0, 1, 1, 0, 32'h700,       32'h308,      32'h30C,      0, 1);
    add(1, 1, 1, 1, 1, 32'h700,       32'h0,        32'h4,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h4,        32'h8,        0, 0);
    // wrap: low bits of tgt forced to 00, npc+4 wraps to 0
    add(0, 1, 1, 1, 0, 32'hFFFF_FFFF, 32'h8,        32'hFFFF_FFFC,0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'hFFFF_FFFC,32'h0,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h0,        32'h4,        0, 0);
    // branch to self at pc=0 repeats
    add(0, 1, 1, 1, 0, 32'h0,         32'h4,        32'h0,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h0,        32'h4,        0, 0);
    add(0, 1, 1, 1, 0, 32'h0,         32'h4,        32'h0,        0, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h0,        32'h4,        0, 0);
    // new request in the delay-slot cycle keeps nullify asserted
    add(0, 1, 1, 1, 1, 32'h80,        32'h4,        32'h80,       1, 0);
    add(0, 1, 1, 0, 1, 32'h0,         32'h80,       32'h84,       1, 0);
    add(0, 1, 0, 0, 0, 32'h0,         32'h84,       32'h88,       0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].le, vecs[i].bv, vecs[i].j, vecs[i].n, vecs[i].tgt);
      chk_all("vec", i, vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_null, vecs[i].e_pend);
    end

    // long stall: taken+nullify request held for 6 cycles while other
    // requests are offered, then applied once
    drive(0, 0, 1, 1, 1, 32'h1234);
    chk_all("stall_load", 0, 32'h84, 32'h88, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 1, 0, 0, 32'h4000 + 32'(k * 16));
      chk_all("stall_hold", k, 32'h84, 32'h88, 0, 1);
    end
    drive(0, 1, 0, 0, 0, 32'h0);
    chk_all("stall_apply", 0, 32'h88, 32'h1234, 1, 0);
    drive(0, 1, 0, 0, 0, 32'h0);
    chk_all("stall_target", 0, 32'h1234, 32'h1238, 0, 0);
    drive(0, 1, 0, 0, 0, 32'h0);
    chk_all("stall_seq", 0, 32'h1238, 32'h123C, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
